// File: rtl/eq_band_mixer.sv
// Graphic-EQ band mixer: snapshots NBANDS filter-bank samples and gains, runs a
// serial multiply-accumulate, then rounds and saturates to a 24-bit output sample.
module eq_band_mixer #(
  parameter int          NBANDS     = 10,
  parameter logic [15:0] GAIN_RESET = 16'h4000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [24*NBANDS-1:0]  i_bands,
  input  logic                  i_gain_we,
  input  logic [3:0]            i_gain_addr,
  input  logic [15:0]           i_gain_data,
  output logic [23:0]           o_data,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_sat,
  output logic                  o_overrun
);

  localparam int KW = $clog2(NBANDS + 1);
  localparam int IW = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBANDS);
  localparam logic [4:0]    NB5    = 5'(NBANDS);
  localparam logic signed [43:0] SAT_HI = 44'sd8388607;
  localparam logic signed [43:0] SAT_LO = -44'sd8388608;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [43:0]   acc_q, acc_d;
  logic [23:0]          data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 sat_q, sat_d;
  logic                 overrun_q, overrun_d;

  logic signed [15:0]   gain_q  [NBANDS];
  logic signed [15:0]   sgain_q [NBANDS];
  logic signed [23:0]   sband_q [NBANDS];

  logic                 capture_s;
  logic                 gain_wr_s;
  logic [IW-1:0]        idx_s;
  logic signed [39:0]   prod_s;
  logic signed [43:0]   rnd_s;
  logic signed [43:0]   shr_s;
  logic [23:0]          res_s;
  logic                 res_sat_s;

  assign idx_s     = k_q[IW-1:0];
  assign prod_s    = sband_q[idx_s] * sgain_q[idx_s];
  assign gain_wr_s = i_gain_we && ({1'b0, i_gain_addr} < NB5);

  // Round half up, arithmetic shift back to sample scale, then clip to 24 bits
  always_comb begin
    rnd_s     = acc_q + 44'sd8192;
    shr_s     = rnd_s >>> 14;
    res_s     = shr_s[23:0];
    res_sat_s = 1'b0;
    if (shr_s > SAT_HI) begin
      res_s     = 24'h7FFFFF;
      res_sat_s = 1'b1;
    end else if (shr_s < SAT_LO) begin
      res_s     = 24'h800000;
      res_sat_s = 1'b1;
    end else begin
      res_sat_s = 1'b0;
    end
  end

  // Next-state and output decode; the extra ACC cycle at k == NBANDS registers the result
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    sat_d     = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_en) begin
          state_d   = ACC;
          capture_s = 1'b1;
          k_d       = {KW{1'b0}};
          acc_d     = 44'sd0;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (k_q == K_LAST) begin
          data_d  = res_s;
          sat_d   = res_sat_s;
          valid_d = 1'b1;
          state_d = OUT;
        end else begin
          acc_d = acc_q + {{4{prod_s[39]}}, prod_s};
          k_d   = k_q + {{(KW-1){1'b0}}, 1'b1};
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d    = (state_d != IDLE);
    overrun_d = i_en && (state_q != IDLE);
  end

  // Control state, accumulator and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      k_q       <= {KW{1'b0}};
      acc_q     <= 44'sd0;
      data_q    <= 24'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end

  // Live gain bank plus the per-sample shadow copy; the snapshot reads pre-write gains
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int b = 0; b < NBANDS; b++) begin
        gain_q[b]  <= GAIN_RESET;
        sgain_q[b] <= GAIN_RESET;
        sband_q[b] <= 24'sd0;
      end
    end else begin
      if (gain_wr_s) begin
        gain_q[i_gain_addr] <= i_gain_data;
      end
      if (capture_s) begin
        for (int b = 0; b < NBANDS; b++) begin
          sgain_q[b] <= gain_q[b];
          sband_q[b] <= i_bands[24*b +: 24];
        end
      end
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_sat     = sat_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Scoreboard bench for eq_band_mixer: expected samples are queued at i_en and
// compared (value, clip flag, latency) when o_valid fires.
module tb_eq_band_mixer;

  localparam int NB = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [24*NB-1:0] bands;
  logic             gain_we;
  logic [3:0]       gain_addr;
  logic [15:0]      gain_data;
  logic [23:0]      data_o;
  logic             valid_o, busy_o, sat_o, overrun_o;

  eq_band_mixer #(.NBANDS(NB), .GAIN_RESET(16'h4000)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_bands     (bands),
    .i_gain_we   (gain_we),
    .i_gain_addr (gain_addr),
    .i_gain_data (gain_data),
    .o_data      (data_o),
    .o_valid     (valid_o),
    .o_busy      (busy_o),
    .o_sat       (sat_o),
    .o_overrun   (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic        s;
    int          due;
  } exp_t;

  exp_t               sbq[$];
  int                 cyc = 0;
  int                 n_checks = 0;
  int                 n_fail = 0;
  logic signed [23:0] band_m [NB];
  logic signed [15:0] mgain  [NB];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_bands();
    for (int b = 0; b < NB; b++) bands[24*b +: 24] = band_m[b];
  endtask

  task automatic push_exp(input logic [23:0] d, input logic s);
    sbq.push_back('{d, s, cyc + 12});
  endtask

  task automatic send_exp(input logic [23:0] d, input logic s);
    pack_bands();
    en = 1'b1;
    push_exp(d, s);
    step();
    en = 1'b0;
  endtask

  task automatic model(output logic [23:0] d, output logic s);
    longint sum;
    longint r;
    sum = 0;
    for (int b = 0; b < NB; b++) sum += longint'(band_m[b]) * longint'(mgain[b]);
    r = (sum + 64'sd8192) >>> 14;
    if (r > 64'sd8388607) begin
      d = 24'h7FFFFF; s = 1'b1;
    end else if (r < -64'sd8388608) begin
      d = 24'h800000; s = 1'b1;
    end else begin
      d = r[23:0];    s = 1'b0;
    end
  endtask

  task automatic write_gain(input logic [3:0] a, input logic [15:0] v);
    gain_we   = 1'b1;
    gain_addr = a;
    gain_data = v;
    step();
    gain_we = 1'b0;
    if (int'(a) < NB) mgain[a] = v;
  endtask

  task automatic set_all_bands(input logic [23:0] v);
    for (int b = 0; b < NB; b++) band_m[b] = v;
  endtask

  task automatic set_all_gains(input logic [15:0] v);
    for (int b = 0; b < NB; b++) write_gain(4'(b), v);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy_o) && n < 60) begin
      step();
      n++;
    end
    check("drain", sbq.size(), 0);
  endtask

  // Output monitor: every o_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (sbq.size() == 0) begin
        check("spurious_valid", 32'(valid_o), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("data", 32'(data_o), 32'(e.d));
        check("sat", 32'(sat_o), 32'(e.s));
        check("latency", cyc, e.due);
        check("busy_at_valid", 32'(busy_o), 32'd1);
      end
    end
  end

  initial begin
    logic [23:0] ed;
    logic        es;
    rst = 1'b1; en = 1'b0; bands = '0;
    gain_we = 1'b0; gain_addr = 4'd0; gain_data = 16'd0;
    for (int b = 0; b < NB; b++) begin band_m[b] = 24'sd0; mgain[b] = 16'sh4000; end
    repeat (2) @(negedge clk);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_sat", 32'(sat_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    step();
    rst = 1'b0;

    // Unity mix
    set_all_bands(24'd100);
    send_exp(24'd1000, 1'b0);
    @(negedge clk);
    check("busy_after_capture", 32'(busy_o), 32'd1);
    wait_drain();
    check("busy_idle", 32'(busy_o), 32'd0);

    // Address guard: out-of-range writes leave the bank alone
    write_gain(4'd12, 16'h0000);
    write_gain(4'd10, 16'h0000);
    send_exp(24'd1000, 1'b0);
    wait_drain();

    // Rounding: only band 0 contributes at gain 0.5
    set_all_gains(16'h0000);
    write_gain(4'd0, 16'h2000);
    set_all_bands(24'h123456);
    band_m[0] = 24'sd1;  send_exp(24'd1, 1'b0);       wait_drain();
    band_m[0] = -24'sd1; send_exp(24'd0, 1'b0);       wait_drain();
    band_m[0] = -24'sd3; send_exp(24'hFFFFFF, 1'b0);  wait_drain();

    // Largest in-range results at unity gain must not clip
    write_gain(4'd0, 16'h4000);
    band_m[0] = 24'h7FFFFF; send_exp(24'h7FFFFF, 1'b0); wait_drain();
    band_m[0] = 24'h800000; send_exp(24'h800000, 1'b0); wait_drain();

    // Saturation both ways
    set_all_gains(16'h7FFF);
    set_all_bands(24'h7FFFFF); send_exp(24'h7FFFFF, 1'b1); wait_drain();
    set_all_bands(24'h800000); send_exp(24'h800000, 1'b1); wait_drain();

    // Pseudo-random mixes against the reference model
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < NB; b++) begin
        int v;
        v = int'($urandom_range(0, 2097151)) - 1048576;
        band_m[b] = v[23:0];
        write_gain(4'(b), 16'($urandom));
      end
      model(ed, es);
      send_exp(ed, es);
      wait_drain();
    end

    // Overrun with a same-cycle gain write: old gain used now, new gain next time
    set_all_gains(16'h4000);
    set_all_bands(24'd100);
    send_exp(24'd1000, 1'b0);
    repeat (4) step();
    en = 1'b1; gain_we = 1'b1; gain_addr = 4'd3; gain_data = 16'h0000;
    step();
    en = 1'b0; gain_we = 1'b0; mgain[3] = 16'sh0000;
    @(negedge clk);
    check("overrun_pulse", 32'(overrun_o), 32'd1);
    step();
    @(negedge clk);
    check("overrun_single", 32'(overrun_o), 32'd0);
    wait_drain();
    send_exp(24'd900, 1'b0);

    // i_en during the o_valid cycle is rejected, the next cycle is accepted
    repeat (11) step();
    en = 1'b1;
    step();
    push_exp(24'd900, 1'b0);
    @(negedge clk);
    check("overrun_at_valid", 32'(overrun_o), 32'd1);
    step();
    en = 1'b0;
    @(negedge clk);
    check("accept_after_valid", 32'(overrun_o), 32'd0);
    check("busy_after_accept", 32'(busy_o), 32'd1);
    wait_drain();

    // Reset in the middle of accumulation aborts the sample and restores gains
    send_exp(24'd900, 1'b0);
    repeat (5) step();
    rst = 1'b1;
    sbq.delete();
    for (int b = 0; b < NB; b++) mgain[b] = 16'sh4000;
    @(negedge clk);
    check("midrst_data", 32'(data_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_valid", 32'(valid_o), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    send_exp(24'd1000, 1'b0);
    wait_drain();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
